// File: rtl/histogram_decomp_scheduler.sv
// Round-robin scheduler that shares one histogram decompressor between NUM_CH job sources.
// Validates each job's bin sum, sequences start/done and forwards beats tagged with the channel id.
module histogram_decomp_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int STREAM_LENGTH = 128,
  parameter int COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1),
  parameter int CH_W          = $clog2(NUM_CH),
  parameter int TIMEOUT       = 2 * STREAM_LENGTH + 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CH-1:0]                 req,
  input  logic [NUM_CH*4*COUNTER_WIDTH-1:0] req_counts,
  output logic [NUM_CH-1:0]                 gnt,
  output logic [NUM_CH-1:0]                 ch_done,
  output logic [NUM_CH-1:0]                 ch_err,
  output logic                              dec_start,
  output logic [COUNTER_WIDTH-1:0]          dec_count_00,
  output logic [COUNTER_WIDTH-1:0]          dec_count_01,
  output logic [COUNTER_WIDTH-1:0]          dec_count_10,
  output logic [COUNTER_WIDTH-1:0]          dec_count_11,
  input  logic                              dec_stream_a,
  input  logic                              dec_stream_b,
  input  logic                              dec_valid,
  input  logic                              dec_done,
  output logic                              out_a,
  output logic                              out_b,
  output logic                              out_valid,
  output logic [CH_W-1:0]                   out_ch,
  output logic                              busy
);

  localparam int CW     = COUNTER_WIDTH;
  localparam int SUM_W  = CW + 2;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int BEAT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, START, RUN, FINISH} state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [CH_W-1:0]     out_ch_reg, out_ch_next;
  logic [CW-1:0]       bin_reg [4];
  logic [BEAT_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [TMR_W-1:0]    timer_reg, timer_next;
  logic [NUM_CH-1:0]   gnt_reg, gnt_next;
  logic [NUM_CH-1:0]   ch_done_reg, ch_done_next;
  logic [NUM_CH-1:0]   ch_err_reg, ch_err_next;
  logic                out_a_reg, out_a_next;
  logic                out_b_reg, out_b_next;
  logic                out_valid_reg, out_valid_next;
  logic                load_job;

  logic [CW-1:0]       ch_bin [NUM_CH][4];
  logic [SUM_W-1:0]    ch_sum [NUM_CH];
  logic [CH_W-1:0]     sel;
  logic                found;
  logic [CH_W-1:0]     sel_inc;
  logic [NUM_CH-1:0]   sel_onehot;
  logic [NUM_CH-1:0]   job_onehot;
  logic                sum_ok;

  // Unpack each channel's four bins and form its sum two bits wider than a bin.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      for (genvar gk = 0; gk < 4; gk++) begin : g_bin
        assign ch_bin[gi][gk] = req_counts[(4*gi+gk)*CW +: CW];
      end
      assign ch_sum[gi] = SUM_W'(ch_bin[gi][0]) + SUM_W'(ch_bin[gi][1])
                        + SUM_W'(ch_bin[gi][2]) + SUM_W'(ch_bin[gi][3]);
    end
  endgenerate

  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[CH_W'(idx)]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  assign sel_inc    = (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
  assign sel_onehot = NUM_CH'(1) << sel;
  assign job_onehot = NUM_CH'(1) << out_ch_reg;
  assign sum_ok     = (ch_sum[sel] == SUM_W'(STREAM_LENGTH));

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    out_ch_next    = out_ch_reg;
    beat_cnt_next  = beat_cnt_reg;
    timer_next     = timer_reg;
    gnt_next       = '0;
    ch_done_next   = '0;
    ch_err_next    = '0;
    out_a_next     = 1'b0;
    out_b_next     = 1'b0;
    out_valid_next = 1'b0;
    load_job       = 1'b0;
    case (state_reg)
      IDLE: begin
        // The requester only sees the registered gnt one cycle later, so skip
        // arbitration in that cycle to avoid granting its stale request twice.
        if (found && gnt_reg == '0) begin
          gnt_next    = sel_onehot;
          rr_ptr_next = sel_inc;
          if (sum_ok) begin
            load_job    = 1'b1;
            out_ch_next = sel;
            state_next  = START;
          end else begin
            ch_err_next = sel_onehot;
          end
        end
      end
      START: begin
        beat_cnt_next = '0;
        timer_next    = '0;
        state_next    = RUN;
      end
      RUN: begin
        out_a_next     = dec_stream_a;
        out_b_next     = dec_stream_b;
        out_valid_next = dec_valid;
        if (dec_valid) beat_cnt_next = beat_cnt_reg + 1'b1;
        timer_next = timer_reg + 1'b1;
        if (dec_done || timer_reg == TMR_W'(TIMEOUT - 1)) begin
          state_next   = FINISH;
          ch_done_next = job_onehot;
          if (!dec_done || beat_cnt_next != BEAT_W'(STREAM_LENGTH))
            ch_err_next = job_onehot;
        end
      end
      FINISH: begin
        if (!dec_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      out_ch_reg    <= '0;
      beat_cnt_reg  <= '0;
      timer_reg     <= '0;
      gnt_reg       <= '0;
      ch_done_reg   <= '0;
      ch_err_reg    <= '0;
      out_a_reg     <= 1'b0;
      out_b_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      for (int k = 0; k < 4; k++) bin_reg[k] <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      out_ch_reg    <= out_ch_next;
      beat_cnt_reg  <= beat_cnt_next;
      timer_reg     <= timer_next;
      gnt_reg       <= gnt_next;
      ch_done_reg   <= ch_done_next;
      ch_err_reg    <= ch_err_next;
      out_a_reg     <= out_a_next;
      out_b_reg     <= out_b_next;
      out_valid_reg <= out_valid_next;
      if (load_job) begin
        for (int k = 0; k < 4; k++) bin_reg[k] <= ch_bin[sel][k];
      end
    end
  end

  assign gnt          = gnt_reg;
  assign ch_done      = ch_done_reg;
  assign ch_err       = ch_err_reg;
  assign dec_start    = (state_reg == START);
  assign busy         = (state_reg != IDLE);
  assign dec_count_00 = bin_reg[0];
  assign dec_count_01 = bin_reg[1];
  assign dec_count_10 = bin_reg[2];
  assign dec_count_11 = bin_reg[3];
  assign out_a        = out_a_reg;
  assign out_b        = out_b_reg;
  assign out_valid    = out_valid_reg;
  assign out_ch       = out_ch_reg;

endmodule
